// File: rtl/oam_dma_controller_pkg.sv
// Shared constants, state encoding and small helpers for the OAM DMA
// controller and its sequencer.
//
// Contents:
//   DMA_REG_ADDR     CPU-visible DMA trigger register address
//   OAM_BASE         first byte of the object attribute memory
//   HRAM_LO/HRAM_HI  high RAM window the CPU may still use during DMA
//   OAM_LEN_DEFAULT  bytes per transfer
//   dma_state_t      sequencer state encoding
//   echo_map()       folds the echo RAM page range onto work RAM
//   cpu_reserved()   true for addresses the CPU keeps during DMA
package oam_dma_controller_pkg;

  localparam logic [15:0] DMA_REG_ADDR        = 16'hFF46;
  localparam logic [15:0] OAM_BASE            = 16'hFE00;
  localparam logic [15:0] HRAM_LO             = 16'hFF80;
  localparam logic [15:0] HRAM_HI             = 16'hFFFE;
  localparam int          OAM_LEN_DEFAULT     = 160;
  localparam int          BYTE_PERIOD_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    GAP   = 2'd3
  } dma_state_t;

  // Source pages 0xE0-0xFF alias the work RAM 0x20 pages below them.
  function automatic logic [7:0] echo_map(input logic [7:0] page);
    return (page >= 8'hE0) ? (page - 8'h20) : page;
  endfunction

  // HRAM and the DMA register stay reachable by the CPU while DMA runs.
  function automatic logic cpu_reserved(input logic [15:0] addr);
    return (addr == DMA_REG_ADDR) || ((addr >= HRAM_LO) && (addr <= HRAM_HI));
  endfunction

endpackage

// File: rtl/oam_dma_seq.sv
// OAM DMA sequencer: owns the transfer FSM, the byte index, the per-byte
// phase counter, the latched source page and the byte in flight.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   start       accepted write to the DMA register this cycle
//   start_data  value written to the DMA register (source page)
//   bus_rdata   memory databus, sampled at the end of a READ cycle
//   state       current sequencer state
//   dma_addr    address the DMA engine wants on the bus this cycle
//   latch       byte read in the READ phase, written back in WRITE
//   dma_active  transfer in progress
module oam_dma_seq
  import oam_dma_controller_pkg::*;
#(
  parameter int BYTE_PERIOD = BYTE_PERIOD_DEFAULT,
  parameter int OAM_LEN     = OAM_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  start_data,
  input  logic [7:0]  bus_rdata,
  output dma_state_t  state,
  output logic [15:0] dma_addr,
  output logic [7:0]  latch,
  output logic        dma_active
);

  localparam int              PW         = (BYTE_PERIOD > 2) ? $clog2(BYTE_PERIOD) : 1;
  localparam logic [PW-1:0]   PHASE_LAST = PW'(BYTE_PERIOD - 1);
  localparam logic [7:0]      IDX_LAST   = 8'(OAM_LEN - 1);

  dma_state_t    state_nx;
  logic [PW-1:0] phase, phase_nx;
  logic [7:0]    idx, idx_nx;
  logic [7:0]    src_hi, src_hi_nx;

  // State register; the read byte is captured on the edge closing READ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      phase  <= '0;
      idx    <= '0;
      src_hi <= '0;
      latch  <= '0;
    end else begin
      state  <= state_nx;
      phase  <= phase_nx;
      idx    <= idx_nx;
      src_hi <= src_hi_nx;
      if (state == READ) begin
        latch <= bus_rdata;
      end
    end
  end

  // Next-state logic. A start always wins, which also covers a retrigger
  // arriving in a GAP cycle: the running copy is dropped and restarts at 0.
  always_comb begin
    state_nx  = state;
    phase_nx  = phase;
    idx_nx    = idx;
    src_hi_nx = src_hi;
    if (start) begin
      state_nx  = READ;
      phase_nx  = '0;
      idx_nx    = '0;
      src_hi_nx = echo_map(start_data);
    end else if (state != IDLE) begin
      if (phase == PHASE_LAST) begin
        phase_nx = '0;
        if (idx == IDX_LAST) begin
          state_nx = IDLE;
          idx_nx   = '0;
        end else begin
          state_nx = READ;
          idx_nx   = idx + 8'd1;
        end
      end else begin
        phase_nx = phase + 1'b1;
        state_nx = (phase == '0) ? WRITE : GAP;
      end
    end
  end

  assign dma_addr   = (state == WRITE) ? (OAM_BASE + {8'h00, idx}) : {src_hi, idx};
  assign dma_active = (state != IDLE);

endmodule

// File: rtl/oam_dma_controller.sv
// OAM DMA controller: sits between the CPU and the memory unit, owns the
// single address/OE/WE/databus path, snoops writes to the DMA register and
// copies OAM_LEN bytes from {page,8'h00} into OAM, one byte per BYTE_PERIOD
// clocks. While a transfer runs the CPU only reaches HRAM and the DMA
// register, and only in GAP cycles.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   cpu_addr     CPU address
//   cpu_wdata    CPU write data
//   cpu_rdata    CPU read data
//   cpu_OE       CPU read strobe
//   cpu_WE       CPU write strobe (wins over cpu_OE)
//   cpu_wait     CPU must hold its access this cycle
//   mem_address  memory unit address
//   mem_OE       memory unit output enable
//   mem_WE       memory unit write enable
//   mem_databus  memory databus, driven here only while mem_WE=1
//   dma_active   transfer in progress
module oam_dma_controller
  import oam_dma_controller_pkg::*;
#(
  parameter int BYTE_PERIOD = BYTE_PERIOD_DEFAULT,
  parameter int OAM_LEN     = OAM_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic        cpu_OE,
  input  logic        cpu_WE,
  output logic        cpu_wait,
  output logic [15:0] mem_address,
  output logic        mem_OE,
  output logic        mem_WE,
  inout  wire  [7:0]  mem_databus,
  output logic        dma_active
);

  dma_state_t  state;
  logic [15:0] dma_addr;
  logic [7:0]  latch;
  logic [7:0]  bus_wdata;
  logic        dma_owns_bus;
  logic        reserved;
  logic        start;

  assign dma_owns_bus = (state == READ) || (state == WRITE);
  assign reserved     = cpu_reserved(cpu_addr);

  // A stalled write to the DMA register is not yet a trigger.
  assign start = cpu_WE && (cpu_addr == DMA_REG_ADDR) && !cpu_wait;

  oam_dma_seq #(
    .BYTE_PERIOD (BYTE_PERIOD),
    .OAM_LEN     (OAM_LEN)
  ) u_seq (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_data (cpu_wdata),
    .bus_rdata  (mem_databus),
    .state      (state),
    .dma_addr   (dma_addr),
    .latch      (latch),
    .dma_active (dma_active)
  );

  // Bus mux and CPU gating. Default is plain pass-through; in READ/WRITE
  // the DMA engine owns the bus, and in GAP only reserved addresses pass.
  always_comb begin
    mem_address = cpu_addr;
    mem_OE      = cpu_OE && !cpu_WE;
    mem_WE      = cpu_WE;
    bus_wdata   = cpu_wdata;
    cpu_rdata   = mem_databus;
    cpu_wait    = 1'b0;
    if (dma_owns_bus) begin
      mem_address = dma_addr;
      mem_OE      = (state == READ);
      mem_WE      = (state == WRITE);
      bus_wdata   = latch;
      cpu_wait    = reserved && (cpu_OE || cpu_WE);
      if (!reserved) begin
        cpu_rdata = 8'hFF;
      end
    end else if (dma_active && !reserved) begin
      mem_OE    = 1'b0;
      mem_WE    = 1'b0;
      cpu_rdata = 8'hFF;
    end
  end

  assign mem_databus = mem_WE ? bus_wdata : 8'hzz;

endmodule
